// File: rtl/rx_rs_pkg.sv
// Shared definitions for the RX RS block scheduler: default block geometry,
// the symbol word type and the write/read controller state encodings.
package rx_rs_pkg;

    localparam int RS_N_DEF  = 204;
    localparam int RS_K_DEF  = 188;
    localparam int CNT_W_DEF = 10;
    localparam int DATA_W    = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_SKIP = 2'd2;

    localparam logic R_IDLE   = 1'b0;
    localparam logic R_STREAM = 1'b1;

endpackage

// File: rtl/rx_rs_blk_sched_if.sv
// Decoder-side word stream: scheduler is the master, RS decoder the slave.
interface rx_rs_blk_sched_if;

    rx_rs_pkg::word_t dec_data;
    logic             dec_valid;
    logic             dec_ready;
    logic             dec_sob;
    logic             dec_eob;
    logic             dec_check;

    modport master (
        output dec_data,
        output dec_valid,
        output dec_sob,
        output dec_eob,
        output dec_check,
        input  dec_ready
    );

    modport slave (
        input  dec_data,
        input  dec_valid,
        input  dec_sob,
        input  dec_eob,
        input  dec_check,
        output dec_ready
    );

endinterface

// File: rtl/rx_rs_pp_buf.sv
// Two-bank block buffer: one write port, one registered read port.
// The address MSB selects the bank, the low CNT_W bits the word index.
module rx_rs_pp_buf
    import rx_rs_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           i_clk,
    input  logic           wr_en,
    input  logic [CNT_W:0] wr_addr,
    input  word_t          wr_data,
    input  logic           rd_en,
    input  logic [CNT_W:0] rd_addr,
    output word_t          rd_data
);

    localparam int DEPTH = 2 ** (CNT_W + 1);

    word_t mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_rs_blk_sched.sv
// RX RS block scheduler: captures framed blocks from block sync into a
// ping-pong buffer and streams complete blocks to the decoder, oldest first.
module rx_rs_blk_sched
    import rx_rs_pkg::*;
#(
    parameter int RS_N  = RS_N_DEF,
    parameter int RS_K  = RS_K_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  word_t             i_data,
    input  logic              i_sof,
    input  logic              i_rs_data_symbol,
    input  logic              i_rs_check_symbol,
    input  logic              i_deskew_aligned,
    rx_rs_blk_sched_if.master dec,
    output logic              o_blk_drop,
    output logic              o_blk_ovf,
    output logic [15:0]       o_blk_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RS_N - 1);
    localparam logic [CNT_W-1:0] K_IDX    = CNT_W'(RS_K);
    localparam logic [CNT_W-1:0] N_IDX    = CNT_W'(RS_N);

    logic [1:0]       w_state, w_state_nxt;
    logic [CNT_W-1:0] w_idx, w_idx_nxt;
    logic [CNT_W-1:0] skip_cnt, skip_cnt_nxt;
    logic             w_bank, w_bank_nxt;
    logic             r_bank;
    logic [1:0]       bank_full;
    logic             sym, start, flag_ok, wr_bank_free, set_full;
    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic             drop_nxt, ovf_nxt;

    logic             r_state;
    logic [CNT_W-1:0] fetch_idx;
    logic             rd_en;
    logic [CNT_W-1:0] rd_idx;
    word_t            rd_data;
    logic             pend;
    logic [CNT_W-1:0] pend_idx;
    logic [1:0]       s_cnt;
    word_t            s0_data, s1_data;
    logic [CNT_W-1:0] s0_idx, s1_idx;
    logic             head_valid, pop, rd_free;
    word_t            head_data;
    logic [CNT_W-1:0] head_idx;
    logic [2:0]       occ_after;

    assign sym     = (i_rs_data_symbol | i_rs_check_symbol) & i_deskew_aligned;
    assign start   = i_sof & sym;
    assign flag_ok = (w_idx < K_IDX) ? (i_rs_data_symbol & ~i_rs_check_symbol)
                                     : (i_rs_check_symbol & ~i_rs_data_symbol);
    // A bank being released by the reader this very cycle is already free.
    assign wr_bank_free = ~bank_full[w_bank] | (rd_free & (r_bank == w_bank));

    always_comb begin
        w_state_nxt  = w_state;
        w_idx_nxt    = w_idx;
        skip_cnt_nxt = skip_cnt;
        w_bank_nxt   = w_bank;
        wr_en        = 1'b0;
        wr_idx       = '0;
        drop_nxt     = 1'b0;
        ovf_nxt      = 1'b0;
        set_full     = 1'b0;
        case (w_state)
            W_FILL: begin
                if (!i_deskew_aligned) begin
                    drop_nxt    = 1'b1;
                    w_state_nxt = W_IDLE;
                end else if (start) begin
                    drop_nxt  = 1'b1;
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    w_idx_nxt = CNT_W'(1);
                end else if (!sym || !flag_ok) begin
                    drop_nxt    = 1'b1;
                    w_state_nxt = W_IDLE;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = w_idx;
                    if (w_idx == LAST_IDX) begin
                        set_full    = 1'b1;
                        w_bank_nxt  = ~w_bank;
                        w_state_nxt = W_IDLE;
                    end else begin
                        w_idx_nxt = w_idx + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    if (wr_bank_free) begin
                        wr_en       = 1'b1;
                        wr_idx      = '0;
                        w_idx_nxt   = CNT_W'(1);
                        w_state_nxt = W_FILL;
                    end else begin
                        ovf_nxt      = 1'b1;
                        skip_cnt_nxt = CNT_W'(1);
                        w_state_nxt  = W_SKIP;
                    end
                end else if (w_state == W_SKIP) begin
                    if (!i_deskew_aligned) begin
                        w_state_nxt = W_IDLE;
                    end else if (sym) begin
                        if (skip_cnt == LAST_IDX) begin
                            w_state_nxt = W_IDLE;
                        end else begin
                            skip_cnt_nxt = skip_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state    <= W_IDLE;
            w_idx      <= '0;
            skip_cnt   <= '0;
            w_bank     <= 1'b0;
            o_blk_drop <= 1'b0;
            o_blk_ovf  <= 1'b0;
        end else begin
            w_state    <= w_state_nxt;
            w_idx      <= w_idx_nxt;
            skip_cnt   <= skip_cnt_nxt;
            w_bank     <= w_bank_nxt;
            o_blk_drop <= drop_nxt;
            o_blk_ovf  <= ovf_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bank_full <= 2'b00;
        end else begin
            if (set_full) begin
                bank_full[w_bank] <= 1'b1;
            end
            if (rd_free) begin
                bank_full[r_bank] <= 1'b0;
            end
        end
    end

    rx_rs_pp_buf #(
        .CNT_W (CNT_W)
    ) u_buf (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr ({w_bank, wr_idx}),
        .wr_data (i_data),
        .rd_en   (rd_en),
        .rd_addr ({r_bank, rd_idx}),
        .rd_data (rd_data)
    );

    // Output head is the oldest skid entry, or the RAM word just read when the
    // skid is empty; a fetch is issued only if its word is guaranteed a slot.
    always_comb begin
        head_valid = (s_cnt != 2'd0) | pend;
        head_data  = (s_cnt != 2'd0) ? s0_data : rd_data;
        head_idx   = (s_cnt != 2'd0) ? s0_idx : pend_idx;
        pop        = head_valid & dec.dec_ready;
        rd_free    = pop & (head_idx == LAST_IDX);
        occ_after  = {1'b0, s_cnt} + {2'b00, pend} - {2'b00, pop};
        rd_en      = 1'b0;
        rd_idx     = fetch_idx;
        if (r_state == R_IDLE) begin
            if (bank_full[r_bank]) begin
                rd_en  = 1'b1;
                rd_idx = '0;
            end
        end else if ((fetch_idx != N_IDX) && (occ_after <= 3'd1)) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= R_IDLE;
            r_bank    <= 1'b0;
            fetch_idx <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            s_cnt     <= 2'd0;
            s0_data   <= '0;
            s1_data   <= '0;
            s0_idx    <= '0;
            s1_idx    <= '0;
            o_blk_cnt <= 16'd0;
        end else begin
            pend <= rd_en;
            if (rd_en) begin
                pend_idx  <= rd_idx;
                fetch_idx <= rd_idx + CNT_W'(1);
            end
            if (r_state == R_IDLE) begin
                if (bank_full[r_bank]) begin
                    r_state <= R_STREAM;
                end
            end else if (rd_free) begin
                r_state   <= R_IDLE;
                r_bank    <= ~r_bank;
                o_blk_cnt <= o_blk_cnt + 16'd1;
            end
            case (s_cnt)
                2'd0: begin
                    if (pend && !pop) begin
                        s0_data <= rd_data;
                        s0_idx  <= pend_idx;
                        s_cnt   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop) begin
                        if (pend) begin
                            s0_data <= rd_data;
                            s0_idx  <= pend_idx;
                        end else begin
                            s_cnt <= 2'd0;
                        end
                    end else if (pend) begin
                        s1_data <= rd_data;
                        s1_idx  <= pend_idx;
                        s_cnt   <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        s0_data <= s1_data;
                        s0_idx  <= s1_idx;
                        if (pend) begin
                            s1_data <= rd_data;
                            s1_idx  <= pend_idx;
                        end else begin
                            s_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign dec.dec_valid = head_valid;
    assign dec.dec_data  = head_valid ? head_data : '0;
    assign dec.dec_sob   = head_valid & (head_idx == '0);
    assign dec.dec_eob   = head_valid & (head_idx == LAST_IDX);
    assign dec.dec_check = head_valid & (head_idx >= K_IDX);

endmodule

// File: tb/tb_rx_rs_blk_sched.sv
// Directed-plus-random bench for rx_rs_blk_sched with RS_N=8, RS_K=6: a
// block-level model predicts delivered words, drop/ovf pulses and block count.
module tb_rx_rs_blk_sched;
    import rx_rs_pkg::*;

    localparam int N  = 8;
    localparam int K  = 6;
    localparam int CW = 4;

    localparam int E_NONE   = 0;
    localparam int E_FLAG   = 1;
    localparam int E_GAP    = 2;
    localparam int E_TRUNC  = 3;
    localparam int E_DESKEW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    word_t       data;
    logic        sof, dsym, csym, aligned;
    logic        drop, ovf;
    logic [15:0] blk_cnt;

    rx_rs_blk_sched_if dec_if ();

    rx_rs_blk_sched #(
        .RS_N  (N),
        .RS_K  (K),
        .CNT_W (CW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_data            (data),
        .i_sof             (sof),
        .i_rs_data_symbol  (dsym),
        .i_rs_check_symbol (csym),
        .i_deskew_aligned  (aligned),
        .dec               (dec_if),
        .o_blk_drop        (drop),
        .o_blk_ovf         (ovf),
        .o_blk_cnt         (blk_cnt)
    );

    always #5 clk = ~clk;

    int          cmp_cnt = 0;
    int          fail_cnt = 0;
    int          cyc = 0;
    int          rdy_mode = 1;
    logic [34:0] exp_q [$];
    int          exp_drop = 0, exp_ovf = 0, exp_blk = 0;
    int          seen_drop = 0, seen_ovf = 0;
    logic        prev_hold = 1'b0;
    logic [34:0] prev_word = '0;
    logic        lat_arm = 1'b0;
    int          first_valid_cyc = -1;
    int          wcyc = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    task automatic checkOutput();
        logic [34:0] cur;
        logic [34:0] expw;
        cur = {dec_if.dec_sob, dec_if.dec_eob, dec_if.dec_check, dec_if.dec_data};
        if (prev_hold) begin
            checkVal("hold_valid", 64'(dec_if.dec_valid), 64'(1));
            checkVal("hold_word", 64'(cur), 64'(prev_word));
        end
        if (lat_arm && dec_if.dec_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (dec_if.dec_valid === 1'b1 && dec_if.dec_ready === 1'b1) begin
            checkVal("word_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                expw = exp_q.pop_front();
                checkVal("word", 64'(cur), 64'(expw));
            end
        end
        if (drop === 1'b1 || ovf === 1'b1) checkVal("drop_ovf_exclusive", 64'(drop & ovf), 64'(0));
        if (drop === 1'b1) seen_drop++;
        if (ovf === 1'b1) seen_ovf++;
        prev_hold = (dec_if.dec_valid === 1'b1) && (dec_if.dec_ready === 1'b0);
        prev_word = cur;
    endtask

    task automatic applyStimulus(input logic s, input logic ds, input logic cs, input logic al, input word_t d);
        @(posedge clk);
        #1;
        cyc++;
        sof = s; dsym = ds; csym = cs; aligned = al; data = d;
        case (rdy_mode)
            0:       dec_if.dec_ready = 1'b0;
            1:       dec_if.dec_ready = 1'b1;
            default: dec_if.dec_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, $urandom());
    endtask

    // Block-level model: at sof the block is captured if fewer than two
    // undelivered blocks remain; only clean captured blocks reach the decoder.
    task automatic sendBlock(input int kind, input int eidx);
        int    outstanding;
        logic  captured;
        word_t blk [N];
        logic  ds, cs, al;
        outstanding = (exp_q.size() + N - 1) / N;
        captured = (outstanding < 2);
        if (!captured) exp_ovf++;
        else if (kind != E_NONE) exp_drop++;
        for (int i = 0; i < N; i++) blk[i] = $urandom();
        if (captured && kind == E_NONE) begin
            for (int i = 0; i < N; i++) exp_q.push_back({(i == 0), (i == N - 1), (i >= K), blk[i]});
            exp_blk++;
        end
        for (int i = 0; i < N; i++) begin
            if (kind == E_TRUNC && i == eidx) break;
            if (kind == E_GAP && i == eidx) idle();
            ds = (i < K); cs = !ds; al = 1'b1;
            if (kind == E_FLAG && i == eidx) begin ds = 1'b0; cs = 1'b1; end
            if (kind == E_DESKEW && i == eidx) al = 1'b0;
            applyStimulus(i == 0, ds, cs, al, blk[i]);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            idle();
            n++;
        end
        checkVal("drain_done", 64'(exp_q.size()), 64'(0));
        repeat (2) idle();
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_valid"}, 64'(dec_if.dec_valid), 64'(0));
        checkVal({tag, "_data"}, 64'(dec_if.dec_data), 64'(0));
        checkVal({tag, "_sob"}, 64'(dec_if.dec_sob), 64'(0));
        checkVal({tag, "_eob"}, 64'(dec_if.dec_eob), 64'(0));
        checkVal({tag, "_check"}, 64'(dec_if.dec_check), 64'(0));
        checkVal({tag, "_drop"}, 64'(drop), 64'(0));
        checkVal({tag, "_ovf"}, 64'(ovf), 64'(0));
        checkVal({tag, "_blk_cnt"}, 64'(blk_cnt), 64'(0));
    endtask

    task automatic checkCounts(input string tag);
        checkVal({tag, "_blk_cnt"}, 64'(blk_cnt), 64'(exp_blk));
        checkVal({tag, "_drops"}, 64'(seen_drop), 64'(exp_drop));
        checkVal({tag, "_ovfs"}, 64'(seen_ovf), 64'(exp_ovf));
    endtask

    initial begin
        rst_n = 1'b0;
        sof = 1'b0; dsym = 1'b0; csym = 1'b0; aligned = 1'b1; data = '0;
        dec_if.dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] clean block, latency");
        rdy_mode = 1;
        lat_arm = 1'b1;
        sendBlock(E_NONE, 0);
        wcyc = cyc;
        drain(100);
        checkVal("latency", 64'(first_valid_cyc - wcyc), 64'(2));
        lat_arm = 1'b0;
        checkCounts("s1");

        $display("[TB] back-to-back blocks with ready low");
        rdy_mode = 0;
        sendBlock(E_NONE, 0);
        sendBlock(E_NONE, 0);
        sendBlock(E_NONE, 0);
        repeat (16) idle();
        rdy_mode = 1;
        drain(100);
        checkCounts("s2");

        $display("[TB] framing errors");
        sendBlock(E_FLAG, 3);
        sendBlock(E_GAP, 4);
        sendBlock(E_NONE, 0);
        drain(100);
        checkCounts("s3");

        $display("[TB] sof inside block");
        sendBlock(E_TRUNC, 5);
        sendBlock(E_NONE, 0);
        drain(100);
        checkCounts("s4");

        $display("[TB] deskew loss while streaming with random ready");
        rdy_mode = 2;
        sendBlock(E_NONE, 0);
        sendBlock(E_DESKEW, 4);
        sendBlock(E_NONE, 0);
        drain(300);
        checkCounts("s5");

        $display("[TB] reset mid-stream");
        rdy_mode = 1;
        sendBlock(E_NONE, 0);
        repeat (3) idle();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkReset("mid_reset");
        exp_q.delete();
        exp_blk = 0;
        prev_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sendBlock(E_NONE, 0);
        drain(100);
        checkCounts("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rx_rs_blk_sched.md
Name: rx_rs_blk_sched

Overview:
Sits between the RX RS block-sync stage and the shared RS decoder.
- Captures the sync stage's 32-bit symbol stream (sof, data-symbol and check-symbol flags) into a two-bank ping-pong block buffer.
- Validates block framing and discards corrupt or partial blocks.
- Schedules complete blocks to the decoder over a valid/ready stream, oldest block first.

Parameters:
RS_N, 204, RS block length in 32-bit words (legal range 2..1023)
RS_K, 188, data words per block (1 <= RS_K < RS_N)
CNT_W, 10, index counter width (must satisfy 2^CNT_W > RS_N)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_data  in  32  symbol word from block sync
i_sof  in  1  first word of an RS block
i_rs_data_symbol  in  1  word is an RS data symbol
i_rs_check_symbol  in  1  word is an RS check symbol
i_deskew_aligned  in  1  lane deskew locked
o_dec_data  out  32  word to decoder
o_dec_valid  out  1  o_dec_data valid
i_dec_ready  in  1  decoder accepts word
o_dec_sob  out  1  first word of block (qualified by valid)
o_dec_eob  out  1  last word of block (qualified by valid)
o_dec_check  out  1  word is a check symbol (index >= RS_K)
o_blk_drop  out  1  one-cycle pulse: block discarded for framing error
o_blk_ovf  out  1  one-cycle pulse: block discarded because both banks were full
o_blk_cnt  out  16  count of blocks fully delivered to the decoder; wraps

Behaviour:
- Reset:
  - All outputs 0.
  - Both banks empty; write FSM in W_IDLE; read FSM in R_IDLE; bank pointers 0.
- Input qualification: sym = i_rs_data_symbol | i_rs_check_symbol, gated by i_deskew_aligned.
- Write FSM, W_IDLE:
  - On i_sof & sym with a free bank: write word to index 0 of the write bank, go to W_FILL with idx = 1.
  - On i_sof & sym with no free bank: pulse o_blk_ovf, go to W_SKIP.
- Write FSM, W_FILL: each sym cycle writes at idx, then idx++.
  - Word at idx < RS_K must have the data flag; word at idx >= RS_K must have the check flag.
  - A flag mismatch, both flags set, or a cycle with no sym is a framing error.
  - On framing error: pulse o_blk_drop, release the bank (no data kept), go to W_IDLE.
  - i_sof while idx != 0: pulse o_blk_drop for the partial block, then restart the block at index 0 in the same bank.
  - Write at idx = RS_N-1 succeeds: mark bank full, toggle write bank, go to W_IDLE.
- Write FSM, W_SKIP: discard words until a sym cycle at count RS_N-1 or the next i_sof.
  - On i_sof, re-evaluate as in W_IDLE in the same cycle.
- i_deskew_aligned low in any write state: abort.
  - Pulse o_blk_drop only if in W_FILL; release the bank; go to W_IDLE.
  - Full banks and the read side are unaffected.
- Read FSM, R_IDLE: when the read bank is full, go to R_STREAM.
  - The read bank pointer always selects the older full bank (strict FIFO order of the two banks).
- Read FSM, R_STREAM:
  - Present words 0..RS_N-1 in order. o_dec_sob on word 0, o_dec_eob on word RS_N-1, o_dec_check when index >= RS_K.
  - Word advances only on o_dec_valid & i_dec_ready.
  - o_dec_valid, data and flags hold stable while ready is low.
  - Throughput is one word per cycle with ready held high; no bubbles inside a block.
  - On acceptance of the eob word: free the bank, toggle the read bank, increment o_blk_cnt, return to R_IDLE.
- Latency: with the read side idle and ready high, word 0 is valid 2 cycles after the cycle writing word RS_N-1.
- Buffer RAM read latency is 1 cycle; the controller uses a 2-entry output skid so ready may drop on any cycle without loss.
- Simultaneous events:
  - The read side freeing a bank in the same cycle as a W_IDLE sof: the bank counts as free (the free check uses next-state).
  - Write to one bank and read from the other in the same cycle is legal.
- o_blk_drop and o_blk_ovf never pulse in the same cycle.

Decomposition:
- Shared package rx_rs_pkg: RS_N/RS_K defaults and write/read FSM state encodings.
- Sub-module rx_rs_pp_buf: 2 x RS_N x 32 dual-port storage, one write port, one registered read port, bank select = address MSB.

Test Plan:
- RS_N=8, RS_K=6; one clean block, ready=1. Expect 8 words out in order, sob on w0, check on w6-7, eob on w7, first valid 2 cycles after w7 input, o_blk_cnt=1.
- Three back-to-back blocks, ready=0 for 40 cycles then 1. Expect blocks 1-2 buffered, third gives o_blk_ovf; blocks 1 then 2 delivered, o_blk_cnt=2.
- Check flag set at index 3, or a one-cycle gap at index 4. Expect o_blk_drop pulse, no output for that block; the next clean block is delivered normally.
- i_sof at index 5 of a block in progress. Expect o_blk_drop once; the new block is captured from index 0 and delivered intact.
- i_deskew_aligned low mid-block while another block streams with random ready. Expect a drop pulse for the filling block; the streaming block completes unaltered.
- Assert reset mid-stream. Expect all outputs 0 immediately, banks empty, o_blk_cnt=0; the next clean block is delivered correctly.
